// File: rtl/mem4_arbiter.sv
// Purpose : round-robin two-requester controller for the byte-cell register memory.
// Latency : write ack 2 cycles after the IDLE grant cycle, read ack 3 cycles after it.
// Backpressure: requesters hold req until ack; the loser keeps req high and wins the next grant.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   req_x/we_x/addr_x/wdata_x        requester x command (x = a, b)
//   ack_x/rdata_x                    one-cycle completion pulse and held read data
//   mem_sel/mem_we/mem_oe/mem_wdata  registered controls to the memory array
//   mem_rdata                        read bus from the array, sampled in RD_WAIT
//   busy/grant_b                     not-IDLE flag and current owner (1 = B)
module mem4_arbiter #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_a,
   input  logic                     we_a,
   input  logic [ADDR_W-1:0]        addr_a,
   input  logic [DATA_W-1:0]        wdata_a,
   output logic                     ack_a,
   output logic [DATA_W-1:0]        rdata_a,
   input  logic                     req_b,
   input  logic                     we_b,
   input  logic [ADDR_W-1:0]        addr_b,
   input  logic [DATA_W-1:0]        wdata_b,
   output logic                     ack_b,
   output logic [DATA_W-1:0]        rdata_b,
   output logic [(1<<ADDR_W)-1:0]   mem_sel,
   output logic                     mem_we,
   output logic                     mem_oe,
   output logic [DATA_W-1:0]        mem_wdata,
   input  logic [DATA_W-1:0]        mem_rdata,
   output logic                     busy,
   output logic                     grant_b
);

   localparam int NSEL = 1 << ADDR_W;

   typedef enum logic [1:0] {IDLE, ACCESS, RD_WAIT, ACK} state_t;

   state_t              state_q, state_d;
   logic                last_grant_q, last_grant_d;   // 1 = B was granted last
   logic                grant_b_q, grant_b_d;
   logic                cmd_we_q, cmd_we_d;
   logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
   logic [NSEL-1:0]     mem_sel_q, mem_sel_d;
   logic                mem_we_q, mem_we_d;
   logic                mem_oe_q, mem_oe_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;     // doubles as the latched write data
   logic                ack_a_q, ack_a_d;
   logic                ack_b_q, ack_b_d;
   logic [DATA_W-1:0]   rdata_a_q, rdata_a_d;
   logic [DATA_W-1:0]   rdata_b_q, rdata_b_d;
   logic                busy_q, busy_d;
   logic                pick_b;
   logic [NSEL-1:0]     sel_onehot;
   logic                drive_mem;

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      grant_b_d    = grant_b_q;
      cmd_we_d     = cmd_we_q;
      cmd_addr_d   = cmd_addr_q;
      mem_wdata_d  = mem_wdata_q;
      rdata_a_d    = rdata_a_q;
      rdata_b_d    = rdata_b_q;
      pick_b       = 1'b0;

      case (state_q)
         IDLE: begin
            if (req_a || req_b) begin
               // On a tie the requester that did not win last time goes first.
               pick_b       = req_b && (!req_a || !last_grant_q);
               grant_b_d    = pick_b;
               last_grant_d = pick_b;
               cmd_we_d     = pick_b ? we_b    : we_a;
               cmd_addr_d   = pick_b ? addr_b  : addr_a;
               mem_wdata_d  = pick_b ? wdata_b : wdata_a;
               state_d      = ACCESS;
            end
         end
         ACCESS:  state_d = cmd_we_q ? ACK : RD_WAIT;
         RD_WAIT: begin
            if (grant_b_q) rdata_b_d = mem_rdata;
            else           rdata_a_d = mem_rdata;
            state_d = ACK;
         end
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Outputs are registered, so they are decoded from the next state.
      sel_onehot             = '0;
      sel_onehot[cmd_addr_d] = 1'b1;
      drive_mem   = (state_d == ACCESS) || (state_d == RD_WAIT);
      mem_sel_d   = drive_mem ? sel_onehot : '0;
      mem_we_d    = (state_d == ACCESS) && cmd_we_d;
      mem_oe_d    = drive_mem && !cmd_we_d;
      ack_a_d     = (state_d == ACK) && !grant_b_d;
      ack_b_d     = (state_d == ACK) && grant_b_d;
      busy_d      = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         grant_b_q    <= 1'b0;
         cmd_we_q     <= 1'b0;
         cmd_addr_q   <= '0;
         mem_sel_q    <= '0;
         mem_we_q     <= 1'b0;
         mem_oe_q     <= 1'b0;
         mem_wdata_q  <= '0;
         ack_a_q      <= 1'b0;
         ack_b_q      <= 1'b0;
         rdata_a_q    <= '0;
         rdata_b_q    <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_b_q    <= grant_b_d;
         cmd_we_q     <= cmd_we_d;
         cmd_addr_q   <= cmd_addr_d;
         mem_sel_q    <= mem_sel_d;
         mem_we_q     <= mem_we_d;
         mem_oe_q     <= mem_oe_d;
         mem_wdata_q  <= mem_wdata_d;
         ack_a_q      <= ack_a_d;
         ack_b_q      <= ack_b_d;
         rdata_a_q    <= rdata_a_d;
         rdata_b_q    <= rdata_b_d;
         busy_q       <= busy_d;
      end
   end

   assign ack_a     = ack_a_q;
   assign ack_b     = ack_b_q;
   assign rdata_a   = rdata_a_q;
   assign rdata_b   = rdata_b_q;
   assign mem_sel   = mem_sel_q;
   assign mem_we    = mem_we_q;
   assign mem_oe    = mem_oe_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = busy_q;
   assign grant_b   = grant_b_q;

endmodule

// File: tb/tb_mem4_arbiter.sv
// Purpose : directed bench for mem4_arbiter with a behavioural 4-byte memory.
// Latency : acks and memory writes are matched in order against expectation queues.
// Backpressure: requesters hold req until ack, as a real master would.
module tb_mem4_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_a, we_a, req_b, we_b;
   logic [1:0] addr_a, addr_b;
   logic [7:0] wdata_a, wdata_b;
   logic       ack_a, ack_b;
   logic [7:0] rdata_a, rdata_b;
   logic [3:0] mem_sel;
   logic       mem_we, mem_oe;
   logic [7:0] mem_wdata, mem_rdata;
   logic       busy, grant_b;

   int pass_cnt = 0;
   int total_cnt = 0;
   int cyc = 0;

   typedef struct {logic b; logic rd; logic [7:0] data;} ack_t;
   typedef struct {logic [3:0] sel; logic [7:0] data;} wr_t;
   ack_t ack_q[$];
   wr_t  wr_q[$];

   logic [7:0] mem [4];
   logic [1:0] sel_idx;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem4_arbiter #(.DATA_W(8), .ADDR_W(2)) dut (
      .clk(clk), .rst(rst),
      .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
      .ack_a(ack_a), .rdata_a(rdata_a),
      .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
      .ack_b(ack_b), .rdata_b(rdata_b),
      .mem_sel(mem_sel), .mem_we(mem_we), .mem_oe(mem_oe),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .busy(busy), .grant_b(grant_b)
   );

   // Behavioural byte array: write on the edge ending the strobe cycle, read while oe.
   always_comb begin
      sel_idx = 2'd0;
      if (mem_sel[1]) sel_idx = 2'd1;
      if (mem_sel[2]) sel_idx = 2'd2;
      if (mem_sel[3]) sel_idx = 2'd3;
   end
   always @(posedge clk) if (mem_we) mem[sel_idx] <= mem_wdata;
   assign mem_rdata = mem_oe ? mem[sel_idx] : 8'h00;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic exp_ack(input logic b, input logic rd, input logic [7:0] data);
      ack_t e;
      e.b = b; e.rd = rd; e.data = data;
      ack_q.push_back(e);
   endtask

   task automatic exp_wr(input logic [3:0] sel, input logic [7:0] data);
      wr_t e;
      e.sel = sel; e.data = data;
      wr_q.push_back(e);
   endtask

   // Monitor: pops expectations whenever the DUT presents an ack or a write strobe.
   always @(negedge clk) begin
      ack_t ea;
      wr_t  ew;
      if (ack_a || ack_b) begin
         if (ack_q.size() == 0) check("ack_unexpected", {30'd0, ack_b, ack_a}, 32'd0);
         else begin
            ea = ack_q.pop_front();
            check("ack_a", ack_a, !ea.b);
            check("ack_b", ack_b, ea.b);
            check("grant_b_at_ack", grant_b, ea.b);
            if (ea.rd) check("rdata", ea.b ? rdata_b : rdata_a, ea.data);
         end
      end
      if (mem_we) begin
         if (wr_q.size() == 0) check("wr_unexpected", mem_sel, 0);
         else begin
            ew = wr_q.pop_front();
            check("wr_sel", mem_sel, ew.sel);
            check("wr_data", mem_wdata, ew.data);
         end
      end
      check("we_oe_exclusive", mem_we && mem_oe, 0);
      if (!mem_we && !mem_oe) check("sel_idle_zero", mem_sel, 0);
   end

   // One complete access; keep=1 leaves req high after the ack.
   task automatic acc(input logic b, input logic we, input logic [1:0] addr,
                      input logic [7:0] wd, input logic keep, output int ack_cyc);
      logic seen;
      if (b) begin req_b = 1'b1; we_b = we; addr_b = addr; wdata_b = wd; end
      else   begin req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = wd; end
      seen = 1'b0;
      ack_cyc = 0;
      for (int n = 0; n < 40 && !seen; n++) begin
         @(negedge clk);
         seen = b ? ack_b : ack_a;
      end
      ack_cyc = cyc;
      if (!seen) check("ack_timeout", seen, 1);
      @(posedge clk); #1;
      if (!keep) begin
         if (b) req_b = 1'b0;
         else   req_a = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int c0, c1, c2, c3, c4;
      rst = 1'b1;
      req_a = 0; we_a = 0; addr_a = 0; wdata_a = 0;
      req_b = 0; we_b = 0; addr_b = 0; wdata_b = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_mem_sel", mem_sel, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_oe", mem_oe, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_ack_a", ack_a, 0);
      check("rst_ack_b", ack_b, 0);
      check("rst_rdata_a", rdata_a, 0);
      check("rst_rdata_b", rdata_b, 0);
      check("rst_busy", busy, 0);
      check("rst_grant_b", grant_b, 0);

      // A writes 0xA5 to addr 2, cycle-by-cycle.
      exp_ack(1'b0, 1'b0, 8'h00);
      exp_wr(4'b0100, 8'hA5);
      @(posedge clk); #1;
      req_a = 1; we_a = 1; addr_a = 2'd2; wdata_a = 8'hA5;
      @(negedge clk);                                   // n: IDLE
      check("t1_busy_n", busy, 0);
      @(negedge clk);                                   // n+1: ACCESS
      check("t1_we_n1", mem_we, 1);
      check("t1_sel_n1", mem_sel, 4'b0100);
      check("t1_busy_n1", busy, 1);
      @(negedge clk);                                   // n+2: ACK
      check("t1_ack_n2", ack_a, 1);
      check("t1_we_n2", mem_we, 0);
      check("t1_busy_n2", busy, 1);
      @(posedge clk); #1 req_a = 0;
      @(negedge clk);
      check("t1_busy_n3", busy, 0);

      // A reads addr 2.
      exp_ack(1'b0, 1'b1, 8'hA5);
      @(posedge clk); #1;
      req_a = 1; we_a = 0; addr_a = 2'd2;
      @(negedge clk);
      @(negedge clk);                                   // n+1
      check("t2_oe_n1", mem_oe, 1);
      check("t2_sel_n1", mem_sel, 4'b0100);
      @(negedge clk);                                   // n+2
      check("t2_oe_n2", mem_oe, 1);
      check("t2_sel_n2", mem_sel, 4'b0100);
      @(negedge clk);                                   // n+3
      check("t2_ack_n3", ack_a, 1);
      check("t2_rdata_a", rdata_a, 8'hA5);
      check("t2_rdata_b", rdata_b, 8'h00);
      check("t2_oe_n3", mem_oe, 0);
      @(posedge clk); #1 req_a = 0;

      // Tie right after reset: expected grant order A, B, A, B.
      @(posedge clk); #1 rst = 1;
      @(posedge clk); #1 rst = 0;
      exp_ack(1'b0, 1'b0, 8'h00); exp_wr(4'b0001, 8'h01);
      exp_ack(1'b1, 1'b0, 8'h00); exp_wr(4'b1000, 8'h02);
      exp_ack(1'b0, 1'b0, 8'h00); exp_wr(4'b0001, 8'h03);
      exp_ack(1'b1, 1'b0, 8'h00); exp_wr(4'b1000, 8'h04);
      fork
         begin
            acc(1'b0, 1'b1, 2'd0, 8'h01, 1'b0, c0);
            acc(1'b0, 1'b1, 2'd0, 8'h03, 1'b0, c1);
         end
         begin
            acc(1'b1, 1'b1, 2'd3, 8'h02, 1'b0, c2);
            acc(1'b1, 1'b1, 2'd3, 8'h04, 1'b0, c3);
         end
      join

      // B streams three writes with req held, then readback.
      exp_ack(1'b1, 1'b0, 8'h00); exp_wr(4'b0001, 8'h11);
      exp_ack(1'b1, 1'b0, 8'h00); exp_wr(4'b0010, 8'h22);
      exp_ack(1'b1, 1'b0, 8'h00); exp_wr(4'b1000, 8'h33);
      acc(1'b1, 1'b1, 2'd0, 8'h11, 1'b1, c0);
      acc(1'b1, 1'b1, 2'd1, 8'h22, 1'b1, c1);
      acc(1'b1, 1'b1, 2'd3, 8'h33, 1'b0, c2);
      check("t4_gap1", c1 - c0, 3);
      check("t4_gap2", c2 - c1, 3);
      exp_ack(1'b0, 1'b1, 8'h11);
      exp_ack(1'b1, 1'b1, 8'h22);
      exp_ack(1'b1, 1'b1, 8'h33);
      acc(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, c3);
      acc(1'b1, 1'b0, 2'd1, 8'h00, 1'b0, c3);
      acc(1'b1, 1'b0, 2'd3, 8'h00, 1'b0, c4);

      // Reset during A's RD_WAIT aborts the read; no ack is expected.
      @(posedge clk); #1;
      req_a = 1; we_a = 0; addr_a = 2'd2;
      @(negedge clk);                                   // n: IDLE
      @(posedge clk); #1;                               // n+1: ACCESS
      @(posedge clk); #1;                               // n+2: RD_WAIT
      rst = 1; req_a = 0;
      @(posedge clk); #1 rst = 0;
      @(negedge clk);
      check("t5_mem_sel", mem_sel, 0);
      check("t5_mem_we", mem_we, 0);
      check("t5_mem_oe", mem_oe, 0);
      check("t5_mem_wdata", mem_wdata, 0);
      check("t5_ack_a", ack_a, 0);
      check("t5_rdata_a", rdata_a, 0);
      check("t5_rdata_b", rdata_b, 0);
      check("t5_busy", busy, 0);
      exp_ack(1'b0, 1'b0, 8'h00); exp_wr(4'b0001, 8'h44);
      exp_ack(1'b1, 1'b0, 8'h00); exp_wr(4'b1000, 8'h55);
      fork
         acc(1'b0, 1'b1, 2'd0, 8'h44, 1'b0, c0);
         acc(1'b1, 1'b1, 2'd3, 8'h55, 1'b0, c1);
      join

      // wdata_a changes during ACCESS; the IDLE-cycle value must be written.
      exp_ack(1'b0, 1'b0, 8'h00);
      exp_wr(4'b0010, 8'h5A);
      @(posedge clk); #1;
      req_a = 1; we_a = 1; addr_a = 2'd1; wdata_a = 8'h5A;
      @(posedge clk); #1 wdata_a = 8'hFF;               // now in ACCESS
      @(negedge clk);
      check("t6_mem_wdata", mem_wdata, 8'h5A);
      @(negedge clk);
      check("t6_ack", ack_a, 1);
      @(posedge clk); #1 req_a = 0;
      repeat (2) @(negedge clk);
      check("t6_mem_byte1", mem[1], 8'h5A);

      check("sb_ack_drained", ack_q.size(), 0);
      check("sb_wr_drained", wr_q.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/mem4_arbiter.md
Name: mem4_arbiter

Overview:
- Two-requester controller for the 4-byte register memory built from one-byte memory cells.
- Arbitrates round-robin between requesters A and B, decodes the 2-bit byte address into the one-hot byte-select lines, and sequences each write or read through a small FSM.
- Returns read data and a one-cycle acknowledge to the winning requester.
- Sits between the CPU-side/test-side masters and the memory array; it is the only driver of the memory's control and data inputs.

Parameters:
- DATA_W, 8, byte width of the memory data path.
- ADDR_W, 2, byte address width; the number of bytes is 2**ADDR_W, giving a 4-bit one-hot select.

Ports:
- clk  input  1  single system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_a  input  1  requester A access request; held high until ack_a is seen.
- we_a  input  1  A command: 1 = write, 0 = read; stable while req_a is high.
- addr_a  input  ADDR_W  A byte address.
- wdata_a  input  DATA_W  A write data.
- ack_a  output  1  one-cycle completion pulse to A.
- rdata_a  output  DATA_W  A read data; valid with ack_a and held until A's next read ack.
- req_b, we_b, addr_b, wdata_b, ack_b, rdata_b  as for A.
- mem_sel  output  2**ADDR_W  one-hot byte select to the memory array.
- mem_we  output  1  write strobe; the memory captures mem_wdata on the edge ending the strobe cycle.
- mem_oe  output  1  output enable; the selected byte drives mem_rdata, otherwise high-Z.
- mem_wdata  output  DATA_W  write data to the array.
- mem_rdata  input  DATA_W  tri-stated read bus from the array.
- busy  output  1  high in every state except IDLE.
- grant_b  output  1  0 = A owns the current access, 1 = B; meaningful while busy.

Behaviour:
- Reset (rst high at a clock edge):
  - state = IDLE; mem_sel = 0, mem_we = 0, mem_oe = 0, mem_wdata = 0.
  - ack_a = ack_b = 0; rdata_a = rdata_b = 0; busy = 0, grant_b = 0.
  - last_grant = B, so A wins the first tie.
  - Reset mid-access aborts it: no ack is issued and no write strobe appears after reset.
- FSM states: IDLE, ACCESS, RD_WAIT, ACK.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one req high: grant it.
  - Both high: grant the requester not equal to last_grant.
  - On a grant: latch the winner's we/addr/wdata into internal command registers, update last_grant and grant_b, go to ACCESS.
  - Requester inputs are not sampled again until the next IDLE.
- ACCESS (one cycle):
  - mem_sel = one-hot(latched addr); mem_wdata = latched wdata.
  - Write: mem_we = 1 for this cycle only, then go to ACK.
  - Read: mem_oe = 1, then go to RD_WAIT.
- RD_WAIT (one cycle):
  - mem_sel and mem_oe stay asserted.
  - mem_rdata is registered into the granted requester's rdata register at the end of the cycle; go to ACK.
- ACK (one cycle):
  - mem_sel, mem_we and mem_oe are all 0.
  - The granted requester's ack is 1; go to IDLE.
- Latency, with the request sampled in IDLE at cycle n:
  - Write: ACCESS n+1, ack n+2, memory updated at the end of n+1.
  - Read: ack n+3, with rdata valid from n+3.
  - Back-to-back throughput is one access per 3 cycles (write) or 4 cycles (read).
- Handshake rules:
  - A requester deasserts req on the edge where it samples its ack high.
  - A req still high in the IDLE cycle after ACK is treated as a new request.
  - A req or command change while not granted is ignored; only the IDLE-cycle value is latched.
  - The non-granted requester keeps its req high and waits; round-robin guarantees it the next grant.
- rdata of the non-granted requester never changes.
- mem_we and mem_oe are never high in the same cycle.
- mem_sel is all-zero whenever both mem_we and mem_oe are 0.

Test Plan:
- Reset then A writes 0xA5 to addr 2 -> mem_sel = 4'b0100 with mem_we high for exactly 1 cycle at n+1; ack_a at n+2; busy high n+1..n+2.
- A reads addr 2 after the write above -> mem_oe high n+1..n+2 with mem_sel = 4'b0100; ack_a at n+3 with rdata_a = 0xA5; rdata_b unchanged at 0x00.
- req_a and req_b rise together right after reset -> A granted first (grant_b = 0); B granted in the next IDLE without dropping req_b; then both again -> A granted (alternation holds).
- B holds req continuously for 3 writes to addrs 0, 1, 3 with data 0x11/0x22/0x33 and A idle -> three grants to B, 3 cycles apart; subsequent reads return 0x11, 0x22, 0x33.
- rst asserted during A's read RD_WAIT cycle -> next cycle all mem_* outputs are 0, no ack_a, rdata_a = 0x00, busy = 0; the next tie goes to A.
- Change wdata_a from 0x5A to 0xFF during A's ACCESS cycle -> the memory stores 0x5A (value latched in IDLE).
